pattern_detect_ctrl: RTL

PATTERN_DETECT_CTRL -- requirements
Module: pattern_detect_ctrl

---
 rtl/pattern_detect_pkg.sv | 24 ++
 rtl/pattern_match_core.sv | 79 +++++++
 rtl/pattern_detect_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pattern_detect_pkg.sv
// ----------------------------------------------------------------------------
// pattern_detect_pkg
// Shared definitions for the serial pattern detector:
//   - controller state encoding
//   - default pattern width / match counter width
//   - configuration loaded by reset (serial pattern 10010, overlapping, no limit)
// ----------------------------------------------------------------------------
package pattern_detect_pkg;

    localparam int MAXLEN_DEF = 8;
    localparam int CNTW_DEF   = 8;

    // Reset pattern is right-aligned: bit [len-1] is the first serial bit.
    localparam logic [7:0] RST_PATTERN = 8'b0001_0010;
    localparam logic [3:0] RST_LEN     = 4'd5;
    localparam logic       RST_OVERLAP = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/pattern_match_core.sv
// ----------------------------------------------------------------------------
// pattern_match_core
// History shift register, fill counter and pattern compare.
//   clk, rst      : clock, synchronous active-high reset
//   clear_i       : wipe history and fill (entry into ARMED)
//   armed_i       : detection active; shift and count this cycle
//   in_i          : serial data bit
//   pattern_i     : right-aligned pattern, bit [len-1] first
//   len_i         : pattern length (already validated, 2..MAXLEN)
//   overlap_i     : 1 = keep fill after a match, 0 = restart fill
//   match_o       : combinational match flag for the current bit
// ----------------------------------------------------------------------------
module pattern_match_core
    import pattern_detect_pkg::*;
#(
    parameter int MAXLEN = MAXLEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              armed_i,
    input  logic              in_i,
    input  logic [MAXLEN-1:0] pattern_i,
    input  logic [3:0]        len_i,
    input  logic              overlap_i,
    output logic              match_o
);

    localparam int FILLW = $clog2(MAXLEN);
    localparam logic [FILLW-1:0] FILL_MAX = FILLW'(MAXLEN - 1);

    logic [MAXLEN-2:0] hist_q, hist_d;
    logic [FILLW-1:0]  fill_q, fill_d;
    logic [MAXLEN-1:0] window;
    logic [MAXLEN-1:0] len_mask;
    logic              fill_ok;

    // Low len bits of the window are {hist[len-2:0], in}.
    assign window = {hist_q, in_i};

    genvar gi;
    generate
        for (gi = 0; gi < MAXLEN; gi++) begin : g_mask
            assign len_mask[gi] = (int'(len_i) > gi);
        end
    endgenerate

    // Need len-1 fresh history bits before the current bit can complete a match.
    assign fill_ok = (int'(fill_q) >= int'(len_i) - 1);
    assign match_o = armed_i && fill_ok &&
                     ((window & len_mask) == (pattern_i & len_mask));

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clear_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (armed_i) begin
            hist_d = window[MAXLEN-2:0];
            if (match_o && !overlap_i) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/pattern_detect_ctrl.sv
// ----------------------------------------------------------------------------
// pattern_detect_ctrl
// Configurable serial pattern detector with IDLE / ARMED / DONE control.
//   clk, rst        : clock, synchronous active-high reset
//   cfg_valid/ready : configuration handshake (ready only in IDLE)
//   cfg_pattern     : pattern bits, bit [len-1] first on the wire
//   cfg_len         : pattern length, legal 2..MAXLEN
//   cfg_overlap     : overlapping (1) or non-overlapping (0) detection
//   cfg_limit       : stop after this many matches, 0 = unlimited
//   cfg_err         : one-cycle pulse after a rejected configuration
//   arm / disarm    : start/restart and stop detection (disarm wins)
//   in              : serial data
//   out             : Mealy match flag
//   match_cnt       : matches since last arm (saturating)
//   busy / done     : in ARMED / in DONE
// ----------------------------------------------------------------------------
module pattern_detect_ctrl
    import pattern_detect_pkg::*;
#(
    parameter int MAXLEN = MAXLEN_DEF,
    parameter int CNTW   = CNTW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [3:0]        cfg_len,
    input  logic              cfg_overlap,
    input  logic [CNTW-1:0]   cfg_limit,
    output logic              cfg_err,
    input  logic              arm,
    input  logic              disarm,
    input  logic              in,
    output logic              out,
    output logic [CNTW-1:0]   match_cnt,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    logic [MAXLEN-1:0] pattern_q;
    logic [3:0]        len_q;
    logic              overlap_q;
    logic [CNTW-1:0]   limit_q;
    logic [CNTW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic              cfg_err_q;
    logic              enter_armed;
    logic              armed;
    logic              match;
    logic              cfg_fire;
    logic              cfg_legal;

    assign armed     = (state_q == ST_ARMED);
    assign cfg_ready = (state_q == ST_IDLE);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign cfg_legal = (cfg_len >= 4'd2) && (int'(cfg_len) <= MAXLEN);
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    pattern_match_core #(
        .MAXLEN (MAXLEN)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (enter_armed),
        .armed_i   (armed),
        .in_i      (in),
        .pattern_i (pattern_q),
        .len_i     (len_q),
        .overlap_i (overlap_q),
        .match_o   (match)
    );

    always_comb begin
        state_d     = state_q;
        enter_armed = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!disarm && arm) begin
                    state_d     = ST_ARMED;
                    enter_armed = 1'b1;
                end
            end
            ST_ARMED: begin
                if (disarm) begin
                    state_d = ST_IDLE;
                end else if (arm) begin
                    // Restart: stay armed but wipe progress.
                    enter_armed = 1'b1;
                end else if (match && (limit_q != '0) && (cnt_inc == limit_q)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (disarm) begin
                    state_d = ST_IDLE;
                end else if (arm) begin
                    state_d     = ST_ARMED;
                    enter_armed = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (enter_armed) begin
            cnt_d = '0;
        end else if (match) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pattern_q <= MAXLEN'(RST_PATTERN);
            len_q     <= RST_LEN;
            overlap_q <= RST_OVERLAP;
            limit_q   <= '0;
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cfg_err_q <= cfg_fire && !cfg_legal;
            if (cfg_fire && cfg_legal) begin
                pattern_q <= cfg_pattern;
                len_q     <= cfg_len;
                overlap_q <= cfg_overlap;
                limit_q   <= cfg_limit;
            end
        end
    end

    assign out       = match;
    assign match_cnt = cnt_q;
    assign busy      = armed;
    assign done      = (state_q == ST_DONE);
    assign cfg_err   = cfg_err_q;

endmodule
